// File: rtl/maroc_sc_sequencer_if.sv
// maroc_sc_sequencer_if: request handshake, config RAM port and MAROC serial bus
interface maroc_sc_sequencer_if #(
    parameter int N_CHIPS = 4,
    parameter int ADDR_W  = 5
);
    localparam int CW = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    logic               start;
    logic [CW-1:0]      chip_sel;
    logic               busy;
    logic               done;
    logic               err;
    logic [15:0]        mism_cnt;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_rdata;
    logic               sr_rst_n;
    logic               sr_in;
    logic [N_CHIPS-1:0] sr_ck;
    logic [N_CHIPS-1:0] sr_out;
    modport master (
        output start, chip_sel, mem_rdata, sr_out,
        input  busy, done, err, mism_cnt, mem_rd_en, mem_addr, sr_rst_n, sr_in, sr_ck
    );
    modport slave (
        input  start, chip_sel, mem_rdata, sr_out,
        output busy, done, err, mism_cnt, mem_rd_en, mem_addr, sr_rst_n, sr_in, sr_ck
    );
endinterface

// File: rtl/maroc_sc_sequencer.sv
// maroc_sc_sequencer: two-pass load and readback verify of a MAROC slow-control chain
module maroc_sc_sequencer #(
    parameter int SC_BITS = 829,
    parameter int N_CHIPS = 4,
    parameter int CLK_DIV = 4,
    parameter int RST_CYC = 16,
    parameter int ADDR_W  = 5
) (
    input  logic ACLK,
    input  logic ARESETN,
    maroc_sc_sequencer_if.slave bus
);
    localparam int BW  = $clog2(SC_BITS);
    localparam int CNW = $clog2((CLK_DIV > RST_CYC) ? CLK_DIV : RST_CYC) + 1;
    localparam int CW  = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SRRST, S_FETCH, S_WAIT, S_LO, S_HI, S_END_PASS, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CNW-1:0]     r_cnt;
    logic [BW-1:0]      r_b, w_b_next;
    logic [31:0]        r_word, w_word;
    logic [CW-1:0]      r_chip;
    logic [N_CHIPS-1:0] w_mask, r_sr_ck;
    logic [15:0]        r_mism;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_pass2, r_busy, r_done, r_err, r_rd_en, r_sr_rst_n, r_sr_in;
    logic               w_acc, w_ph_end, w_cmp, w_miss;

    assign w_acc    = (r_state == S_IDLE) && bus.start;
    assign w_ph_end = (r_cnt == CNW'(CLK_DIV - 1));
    // an out-of-range chip_sel gives an all-zero mask: no clock, and sr_out reads as stuck 0
    assign w_mask   = N_CHIPS'(1) << r_chip;
    assign w_cmp    = r_pass2 && (r_state == S_HI) && (r_cnt == '0);
    assign w_miss   = (|(bus.sr_out & w_mask)) != r_word[r_b[4:0]];
    // RAM data is used straight off the bus while it is being latched, so sr_in is ready on LO entry
    assign w_word   = (r_state == S_WAIT) ? bus.mem_rdata : r_word;
    assign w_b_next = (r_state == S_SRRST || r_state == S_END_PASS) ? BW'(SC_BITS - 1) :
                      (r_state == S_HI && w_ph_end && r_b != '0) ? r_b - 1'b1 : r_b;

    // next-state: the last bit of pass 2 goes straight to DONE, pass 1 goes through END_PASS
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = bus.start ? S_SRRST : S_IDLE;
            S_SRRST:    w_next = (r_cnt == CNW'(RST_CYC - 1)) ? S_FETCH : S_SRRST;
            S_FETCH:    w_next = S_WAIT;
            S_WAIT:     w_next = S_LO;
            S_LO:       w_next = w_ph_end ? S_HI : S_LO;
            S_HI:       w_next = !w_ph_end ? S_HI :
                                 (r_b == '0) ? (r_pass2 ? S_DONE : S_END_PASS) :
                                 (r_b[4:0] == 5'd0) ? S_FETCH : S_LO;
            S_END_PASS: w_next = S_FETCH;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // datapath and registered outputs, all derived from the upcoming state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt      <= '0;
            r_b        <= '0;
            r_word     <= '0;
            r_chip     <= '0;
            r_pass2    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mism     <= '0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_sr_rst_n <= 1'b1;
            r_sr_in    <= 1'b0;
            r_sr_ck    <= '0;
        end else begin
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_b        <= w_b_next;
            r_busy     <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);
            r_rd_en    <= (w_next == S_FETCH);
            r_sr_rst_n <= (w_next != S_SRRST);
            r_sr_ck    <= (w_next == S_HI) ? w_mask : '0;
            if (w_next == S_FETCH) r_addr <= ADDR_W'(w_b_next >> 5);
            if (w_next == S_LO && r_state != S_LO) r_sr_in <= w_word[w_b_next[4:0]];
            if (r_state == S_WAIT) r_word <= bus.mem_rdata;
            if (r_state == S_END_PASS) r_pass2 <= 1'b1;
            if (w_acc) begin
                r_chip  <= bus.chip_sel;
                r_err   <= 1'b0;
                r_mism  <= '0;
                r_pass2 <= 1'b0;
            end
            if (w_cmp && w_miss) begin
                r_err  <= 1'b1;
                r_mism <= (r_mism == 16'hFFFF) ? r_mism : r_mism + 16'd1;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mism_cnt  = r_mism;
    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_addr  = r_addr;
    assign bus.sr_rst_n  = r_sr_rst_n;
    assign bus.sr_in     = r_sr_in;
    assign bus.sr_ck     = r_sr_ck;
endmodule

// File: tb/tb_maroc_sc_sequencer.sv
// tb_maroc_sc_sequencer: randomized load/verify sequences against a shift-register chip model
module tb_maroc_sc_sequencer;
    localparam int SC  = 100;
    localparam int NCH = 3;
    localparam int CD  = 2;
    localparam int RC  = 16;
    localparam int AW  = 5;
    localparam int NW  = (SC + 31) / 32;
    localparam int LAT = 1 + RC + 2 * (SC * 2 * CD + NW * 2) + 1;
    localparam int LIM = LAT + 64;
    localparam logic [29:0] RST_VEC = {1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 5'h00, 1'b1, 1'b0, 3'b000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_run = 0, n_fail = 0;
    logic [31:0] mem [32];
    int mdl_chip = 0, inv_pos = -1000, fall_cnt = 0, n_done = 0, bad_ck = 0, cyc = 0;
    bit stuck = 1'b0, other = 1'b1, ck_prev = 1'b0, d_lat = 1'b0;
    logic [NCH-1:0] sel_m = '0;
    logic [SC-1:0] sr_mdl = '0;
    bit got[$];
    logic busy1, err1;
    logic [15:0] mism1;

    maroc_sc_sequencer_if #(.N_CHIPS(NCH), .ADDR_W(AW)) bus ();

    maroc_sc_sequencer #(.SC_BITS(SC), .N_CHIPS(NCH), .CLK_DIV(CD), .RST_CYC(RC), .ADDR_W(AW)) dut (
        .ACLK(clk),
        .ARESETN(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // config RAM: one-cycle read latency, garbage when not strobed
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : 32'hDEAD_BEEF;

    // modelled chip drives its chain output (optionally stuck or with one inverted position)
    always_comb
        for (int i = 0; i < NCH; i++)
            bus.sr_out[i] = (i == mdl_chip) ? (!stuck && (sr_mdl[SC-1] ^ (fall_cnt == SC + inv_pos))) : other;

    // chip model: captures sr_in on rising sr_ck, shifts on falling sr_ck; also monitors sr_ck and done
    always @(negedge clk) begin
        if (bus.done) n_done++;
        if ((bus.sr_ck & ~sel_m) != '0) bad_ck++;
        if (!rst_n || !bus.sr_rst_n) begin
            sr_mdl = '0;
            fall_cnt = 0;
            ck_prev = 1'b0;
        end else if (mdl_chip < NCH) begin
            if (bus.sr_ck[mdl_chip] && !ck_prev) begin
                d_lat = bus.sr_in;
                got.push_back(bus.sr_in);
            end
            if (!bus.sr_ck[mdl_chip] && ck_prev) begin
                sr_mdl = {sr_mdl[SC-2:0], d_lat};
                fall_cnt++;
            end
            ck_prev = bus.sr_ck[mdl_chip];
        end
    end

    function automatic logic [29:0] obs_vec();
        return {bus.busy, bus.done, bus.err, bus.mism_cnt, bus.mem_rd_en, bus.mem_addr,
                bus.sr_rst_n, bus.sr_in, bus.sr_ck};
    endfunction

    // reference stream: image bits SC-1 down to 0, sent twice
    function automatic int stream_errs();
        int e = 0, k = 0;
        if (got.size() != 2 * SC) return -1;
        for (int p = 0; p < 2; p++)
            for (int b = SC - 1; b >= 0; b--) begin
                if (got[k] !== mem[b / 32][b % 32]) e++;
                k++;
            end
        return e;
    endfunction

    function automatic int ones();
        int n = 0;
        for (int b = 0; b < SC; b++) n += int'(mem[b / 32][b % 32]);
        return n;
    endfunction

    task automatic fill_image();
        for (int w = 0; w < 32; w++) mem[w] = $urandom;
    endtask

    task automatic run_seq(input int chip, input bit hold);
        got.delete();
        n_done = 0;
        bad_ck = 0;
        mdl_chip = chip;
        sel_m = '0;
        if (chip < NCH) sel_m[chip] = 1'b1;
        @(negedge clk);
        bus.chip_sel = chip[1:0];
        bus.start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            bus.start = hold;
            cyc++;
            if (cyc == 1) begin
                busy1 = bus.busy;
                err1 = bus.err;
                mism1 = bus.mism_cnt;
            end
        end while (!bus.done && cyc < LIM);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.chip_sel = '0;
        repeat (3) @(negedge clk);
        n_run++;
        if (obs_vec() !== RST_VEC) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs_vec(), RST_VEC); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_run++;
        if (obs_vec() !== RST_VEC) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs_vec(), RST_VEC); end
    endtask

    task automatic test_loopback();
        for (int r = 0; r < 4; r++) begin
            int chip;
            if (r == 0) begin
                mem[0] = 32'hA5A5_0F0F; mem[1] = 32'h0000_00C3; mem[2] = 32'h1234_5678; mem[3] = 32'h0000_000F;
                chip = 2;
            end else begin
                fill_image();
                chip = $urandom_range(0, NCH - 1);
            end
            stuck = 1'b0; inv_pos = -1000; other = 1'b1;
            run_seq(chip, 1'b0);
            repeat (4) @(negedge clk);
            n_run++;
            if (cyc !== LAT) begin n_fail++; $display("FAIL loop_latency: got %0d cycles expected %0d", cyc, LAT); end
            n_run++;
            if (busy1 !== 1'b1) begin n_fail++; $display("FAIL loop_busy_after_start: got %b expected 1", busy1); end
            n_run++;
            if (stream_errs() !== 0) begin n_fail++; $display("FAIL loop_stream: got %0d bad bits (size %0d) expected 0", stream_errs(), got.size()); end
            n_run++;
            if ({bus.err, bus.mism_cnt} !== 17'h0) begin n_fail++; $display("FAIL loop_result: got err=%b mism=%0d expected 0/0", bus.err, bus.mism_cnt); end
            n_run++;
            if (bad_ck !== 0) begin n_fail++; $display("FAIL loop_other_ck: got %0d toggling samples expected 0", bad_ck); end
            n_run++;
            if (n_done !== 1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL loop_done: got %0d pulses busy=%b expected 1/0", n_done, bus.busy); end
        end
    endtask

    task automatic test_inverted();
        for (int r = 0; r < 2; r++) begin
            fill_image();
            stuck = 1'b0; other = 1'b1;
            inv_pos = (r == 0) ? 5 : int'($urandom_range(0, SC - 1));
            run_seq($urandom_range(0, NCH - 1), 1'b0);
            repeat (20) @(negedge clk);
            n_run++;
            if (stream_errs() !== 0) begin n_fail++; $display("FAIL inv_stream: got %0d bad bits expected 0", stream_errs()); end
            n_run++;
            if ({bus.err, bus.mism_cnt} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL inv_result pos %0d: got err=%b mism=%0d expected 1/1", inv_pos, bus.err, bus.mism_cnt); end
        end
        inv_pos = -1000;
    endtask

    task automatic test_stuck();
        for (int r = 0; r < 2; r++) begin
            int exp_m;
            if (r == 0) for (int w = 0; w < 32; w++) mem[w] = 32'hFFFF_FFFF;
            else fill_image();
            exp_m = ones();
            stuck = 1'b1; other = 1'b1;
            run_seq($urandom_range(0, NCH - 1), 1'b0);
            repeat (4) @(negedge clk);
            n_run++;
            if ({err1, mism1} !== 17'h0) begin n_fail++; $display("FAIL stuck_clear_on_start: got err=%b mism=%0d expected 0/0", err1, mism1); end
            n_run++;
            if (bus.mism_cnt !== 16'(exp_m) || bus.err !== (exp_m > 0)) begin n_fail++; $display("FAIL stuck_result: got err=%b mism=%0d expected mism=%0d", bus.err, bus.mism_cnt, exp_m); end
            n_run++;
            if (cyc !== LAT) begin n_fail++; $display("FAIL stuck_latency: got %0d expected %0d", cyc, LAT); end
        end
        stuck = 1'b0;
    endtask

    task automatic test_bad_chip();
        int exp_m;
        fill_image();
        exp_m = ones();
        other = 1'b0;
        run_seq(3, 1'b0);
        repeat (4) @(negedge clk);
        n_run++;
        if (bad_ck !== 0) begin n_fail++; $display("FAIL badchip_ck: got %0d toggling samples expected 0", bad_ck); end
        n_run++;
        if (bus.mism_cnt !== 16'(exp_m) || bus.err !== (exp_m > 0)) begin n_fail++; $display("FAIL badchip_result: got err=%b mism=%0d expected mism=%0d", bus.err, bus.mism_cnt, exp_m); end
        n_run++;
        if (cyc !== LAT) begin n_fail++; $display("FAIL badchip_latency: got %0d expected %0d", cyc, LAT); end
        other = 1'b1;
    endtask

    task automatic test_back_to_back();
        int c2;
        fill_image();
        run_seq(1, 1'b1);
        n_run++;
        if (cyc !== LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, LAT); end
        @(posedge clk);
        #1;
        n_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got busy,done=%b%b expected 00", bus.busy, bus.done); end
        got.delete();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_run++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy); end
        n_run++;
        if (n_done !== 1) begin n_fail++; $display("FAIL b2b_one_done: got %0d pulses expected 1", n_done); end
        c2 = 1;
        n_done = 0;
        while (!bus.done && c2 < LIM) begin
            @(posedge clk);
            #1;
            c2++;
        end
        repeat (4) @(negedge clk);
        n_run++;
        if (c2 !== LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", c2, LAT); end
        n_run++;
        if (stream_errs() !== 0 || {bus.err, bus.mism_cnt} !== 17'h0) begin n_fail++; $display("FAIL b2b_second_result: got %0d bad bits err=%b mism=%0d expected 0", stream_errs(), bus.err, bus.mism_cnt); end
    endtask

    task automatic test_abort();
        int w;
        fill_image();
        mdl_chip = 0;
        sel_m = 3'b001;
        @(negedge clk);
        bus.chip_sel = 2'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat ($urandom_range(0, 150)) @(posedge clk);
        #1;
        w = 0;
        while (bus.sr_ck === '0 && w < LIM) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_run++;
        if (bus.sr_ck !== 3'b001) begin n_fail++; $display("FAIL abort_reach_hi: got sr_ck=%b expected 001", bus.sr_ck); end
        rst_n = 1'b0;
        #1;
        n_run++;
        if (obs_vec() !== RST_VEC) begin n_fail++; $display("FAIL abort_reset: got %h expected %h", obs_vec(), RST_VEC); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if (obs_vec() !== RST_VEC) begin n_fail++; $display("FAIL abort_idle: got %h expected %h", obs_vec(), RST_VEC); end
        run_seq($urandom_range(0, NCH - 1), 1'b0);
        repeat (4) @(negedge clk);
        n_run++;
        if (cyc !== LAT || stream_errs() !== 0 || {bus.err, bus.mism_cnt} !== 17'h0) begin
            n_fail++;
            $display("FAIL abort_restart: got %0d cycles %0d bad bits err=%b mism=%0d expected %0d/0/0/0", cyc, stream_errs(), bus.err, bus.mism_cnt, LAT);
        end
    endtask

    initial begin
        for (int w = 0; w < 32; w++) mem[w] = '0;
        test_reset();
        test_loopback();
        test_inverted();
        test_stuck();
        test_bad_chip();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
